// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART transmitter.
// The planned frame receiver uses the same constants.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int def_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Keeps only the configured number of payload bits.
  function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
    logic [7:0] m;
    case (data_bits)
      DB_5:    m = 8'h1F;
      DB_6:    m = 8'h3F;
      DB_7:    m = 8'h7F;
      DB_8:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: latches the divisor when a frame is accepted and
// flags the last clock of every bit period while enabled.
module uart_baud_gen #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 5208
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic             bit_end_o
);

  localparam logic [DIV_W-1:0] DEF_DIV_W = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_end_o = en_i && (cnt_q == div_q - ONE);

  // Divisors 0 and 1 cannot time a bit, so they fall back to the default.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      div_d = (div_i <= ONE) ? DEF_DIV_W : div_i;
      cnt_d = '0;
    end else if (!en_i || bit_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DEF_DIV_W;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Configurable UART transmitter: 5-8 data bits, optional parity, 1/2 stop
// bits, runtime divisor, valid/ready handshake for back-to-back frames.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DIV_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             rs232_tx
);

  localparam int DEF_DIV = def_div(CLK_FREQ, BAUD_RATE);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic [7:0] data_q, data_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic       stop2_q, stop2_d;
  logic       ready_q, busy_q, done_q, line_q;
  logic       done_d, line_d;
  logic       accept, bit_end;

  assign accept = tx_valid && ready_q;

  uart_baud_gen #(
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .div_i    (cfg_div),
    .en_i     (state_q != ST_IDLE),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    last_idx_d = last_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d     = tx_data & data_mask(cfg_data_bits);
          last_idx_d = {1'b1, cfg_data_bits};
          par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
          par_bit_d  = (^(tx_data & data_mask(cfg_data_bits))) ^ (cfg_parity == PAR_ODD);
          stop2_d    = cfg_stop2;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx_q) begin
            bit_idx_d = 3'd0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            stop_idx_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so the pin is a plain register.
  always_comb begin
    case (state_d)
      ST_START:  line_d = START_BIT;
      ST_DATA:   line_d = data_d[bit_idx_d];
      ST_PARITY: line_d = par_bit_d;
      default:   line_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      data_q     <= 8'h00;
      last_idx_q <= 3'd7;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      line_q     <= STOP_BIT;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      last_idx_q <= last_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      line_q     <= line_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign rs232_tx = line_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: directed table, random frames against
// a bit-list reference model, back-to-back and mid-frame reset sequences.
module tb_uart_frame_tx;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 9600;
  localparam int DIV_W     = 16;
  localparam int DEF_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int MAXC      = 60000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tx_valid = 1'b0;
  logic             tx_ready, tx_busy, tx_done, rs232_tx;
  logic [7:0]       tx_data = 8'h00;
  logic [1:0]       cfg_data_bits = 2'b11;
  logic [1:0]       cfg_parity = 2'b00;
  logic             cfg_stop2 = 1'b0;
  logic [DIV_W-1:0] cfg_div = 16'd4;

  int checks = 0;
  int errors = 0;
  int busy_bad;
  logic wave[$];
  logic exp_wave[$];

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .DIV_W    (DIV_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .cfg_div      (cfg_div),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rs232_tx     (rs232_tx)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  db;
    logic [1:0]  par;
    logic        st2;
    logic [15:0] div;
    int          exp_len;
    logic        has_par;
    logic        exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference: list of bit values for the frame, each stretched to div samples.
  function automatic void build_model(input logic [7:0] d, input logic [1:0] db,
                                      input logic [1:0] par, input logic st2,
                                      input logic [15:0] div);
    int n = int'(db) + 5;
    int e = (div <= 16'd1) ? DEF_DIV : int'(div);
    int ones = 0;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par == 2'b01) bits.push_back((ones % 2) == 1);
    if (par == 2'b10) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    exp_wave.delete();
    foreach (bits[k]) for (int j = 0; j < e; j++) exp_wave.push_back(bits[k]);
  endfunction

  task automatic collect(output logic done_seen);
    wave.delete();
    done_seen = 1'b0;
    busy_bad = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      if (tx_done) begin
        done_seen = 1'b1;
        break;
      end
      wave.push_back(rs232_tx);
      if (!tx_busy || tx_ready) busy_bad++;
    end
  endtask

  task automatic compare_wave(input string name);
    int bad = 0;
    int n = (wave.size() < exp_wave.size()) ? wave.size() : exp_wave.size();
    check({name, "_len"}, wave.size(), exp_wave.size());
    for (int i = 0; i < n; i++) if (wave[i] !== exp_wave[i]) bad++;
    check({name, "_wave_bad_samples"}, bad, 0);
    check({name, "_busy_bad_cycles"}, busy_bad, 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                           input logic st2, input logic [15:0] div, input string name);
    logic done_seen;
    @(negedge clk);
    check({name, "_ready_before"}, tx_ready, 1'b1);
    tx_data = d; cfg_data_bits = db; cfg_parity = par; cfg_stop2 = st2; cfg_div = div;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    // Scramble inputs: the frame must use what was captured at accept.
    tx_data = 8'($urandom); cfg_data_bits = 2'($urandom); cfg_parity = 2'($urandom);
    cfg_stop2 = 1'($urandom); cfg_div = 16'($urandom_range(2, 9));
    collect(done_seen);
    check({name, "_done_seen"}, done_seen, 1'b1);
    check({name, "_end_line_ready_busy"}, {rs232_tx, tx_ready, tx_busy}, 3'b110);
    build_model(d, db, par, st2, div);
    compare_wave(name);
    @(negedge clk);
    check({name, "_done_width"}, tx_done, 1'b0);
  endtask

  initial begin
    logic done_seen;
    int   dones;
    int   n, e, idx;

    vecs[0] = '{8'h55, 2'b11, 2'b00, 1'b0, 16'd4, 40, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 2'b11, 2'b01, 1'b0, 16'd4, 44, 1'b1, 1'b1};
    vecs[2] = '{8'h01, 2'b11, 2'b10, 1'b0, 16'd4, 44, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 2'b00, 2'b10, 1'b1, 16'd3, 27, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 2'b11, 2'b00, 1'b1, 16'd5, 55, 1'b0, 1'b0};
    vecs[5] = '{8'h3A, 2'b10, 2'b11, 1'b0, 16'd2, 18, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 2'b11, 2'b00, 1'b0, 16'd0, 52080, 1'b0, 1'b0};

    #12;
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_line", rs232_tx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_line", rs232_tx, 1'b1);

    foreach (vecs[v]) begin
      run_frame(vecs[v].data, vecs[v].db, vecs[v].par, vecs[v].st2, vecs[v].div,
                $sformatf("vec%0d", v));
      check($sformatf("vec%0d_frame_cycles", v), wave.size(), vecs[v].exp_len);
      if (vecs[v].has_par) begin
        n = int'(vecs[v].db) + 5;
        e = int'(vecs[v].div);
        idx = (1 + n) * e + e / 2;
        check($sformatf("vec%0d_parity_bit", v),
              (idx < wave.size()) ? wave[idx] : 1'bx, vecs[v].exp_par);
      end
    end

    for (int r = 0; r < 16; r++)
      run_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                16'($urandom_range(2, 6)), $sformatf("rnd%0d", r));

    // Back to back with valid held high, cfg disturbed during the first frame.
    @(negedge clk);
    tx_data = 8'hA5; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    cfg_div = 16'd4; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h3C;
    fork
      collect(done_seen);
      begin
        repeat (8) @(negedge clk);
        cfg_div = 16'd7; cfg_parity = 2'b10; cfg_data_bits = 2'b00; cfg_stop2 = 1'b1;
        repeat (10) @(negedge clk);
        cfg_div = 16'd4; cfg_parity = 2'b00; cfg_data_bits = 2'b11; cfg_stop2 = 1'b0;
      end
    join
    check("b2b1_done_seen", done_seen, 1'b1);
    check("b2b_gap_line_ready_busy", {rs232_tx, tx_ready, tx_busy}, 3'b110);
    build_model(8'hA5, 2'b11, 2'b00, 1'b0, 16'd4);
    compare_wave("b2b1");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    collect(done_seen);
    check("b2b2_done_seen", done_seen, 1'b1);
    build_model(8'h3C, 2'b11, 2'b00, 1'b0, 16'd4);
    compare_wave("b2b2");
    @(negedge clk);

    // Reset during the third data bit of 0xFB (that bit is 0 on the line).
    @(negedge clk);
    tx_data = 8'hFB; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    cfg_div = 16'd4; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("mid_rst_line_before", rs232_tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_line_async", rs232_tx, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (tx_done) dones++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_done || rs232_tx !== 1'b1) dones++;
    end
    check("mid_rst_no_done_or_activity", dones, 0);
    run_frame(8'h0F, 2'b11, 2'b00, 1'b0, 16'd4, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
